// File: rtl/muxn_arb.sv
// muxn_arb: N-channel registered selector, direct or round-robin, with a ready/valid output.
// Optional build macro MUXN_STATS_EN adds the 16-bit xfer_cnt transfer counter port.
module muxn_arb #(
  parameter int  W  = 32,
  parameter int  N  = 16,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N*W-1:0] in,
  input  logic [N-1:0]   req,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [N-1:0]   grant,
  output logic [W-1:0]   out,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
`ifdef MUXN_STATS_EN
  ,
  output logic [15:0]    xfer_cnt
`endif
);

  logic [W-1:0]  out_q, out_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;
  logic [SW-1:0] ptr_q, ptr_d;

  logic          load;
  logic          hit;
  logic [SW-1:0] win;
  logic [W-1:0]  win_data;
  logic [SW:0]   cand;

  assign load = !out_valid_q || out_ready;

  // Winner selection: direct index check, or a circular search starting at ptr.
  always_comb begin
    hit  = 1'b0;
    win  = '0;
    cand = '0;
    if (mode) begin
      for (int i = 0; i < N; i++) begin
        cand = {1'b0, ptr_q} + (SW+1)'(i);
        if (cand >= (SW+1)'(N)) cand = cand - (SW+1)'(N);
        if (!hit && req[cand[SW-1:0]]) begin
          hit = 1'b1;
          win = cand[SW-1:0];
        end
      end
    end else if (({1'b0, sel} < (SW+1)'(N)) && req[sel]) begin
      hit = 1'b1;
      win = sel;
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < N; k++) begin
      if (win == SW'(k)) win_data = in[k*W +: W];
    end
  end

  // Grant is masked while in reset so producers never see a phantom acknowledge.
  always_comb begin
    grant = '0;
    for (int k = 0; k < N; k++) begin
      grant[k] = rst_n && load && hit && (win == SW'(k));
    end
  end

  always_comb begin
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = hit;
      if (hit) begin
        out_d    = win_data;
        out_ch_d = win;
      end
      if (hit && mode) ptr_d = (win == SW'(N-1)) ? '0 : win + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

`ifdef MUXN_STATS_EN
  logic [15:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid_q && out_ready) xfer_cnt_d = xfer_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) xfer_cnt_q <= '0;
    else        xfer_cnt_q <= xfer_cnt_d;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_muxn_arb.sv
// Bench for muxn_arb: three instances (N=16/W=32, N=4/W=8, N=5/W=8) driven from one vector table.
// Optional MUXN_STATS_EN checks the transfer counter.
module tb_muxn_arb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [511:0] a_in;  logic [15:0] a_req, a_grant; logic a_mode; logic [3:0] a_sel, a_out_ch;
  logic [31:0]  a_out; logic a_out_valid, a_out_ready;
  logic [31:0]  b_in;  logic [3:0] b_req, b_grant;  logic b_mode; logic [1:0] b_sel, b_out_ch;
  logic [7:0]   b_out; logic b_out_valid, b_out_ready;
  logic [39:0]  c_in;  logic [4:0] c_req, c_grant;  logic c_mode; logic [2:0] c_sel, c_out_ch;
  logic [7:0]   c_out; logic c_out_valid, c_out_ready;
`ifdef MUXN_STATS_EN
  logic [15:0] a_xfer, b_xfer, c_xfer;
`endif

  muxn_arb #(.W(32), .N(16)) u_a (
    .clk(clk), .rst_n(rst_n), .in(a_in), .req(a_req), .mode(a_mode), .sel(a_sel),
    .grant(a_grant), .out(a_out), .out_ch(a_out_ch), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
`ifdef MUXN_STATS_EN
    , .xfer_cnt(a_xfer)
`endif
  );

  muxn_arb #(.W(8), .N(4)) u_b (
    .clk(clk), .rst_n(rst_n), .in(b_in), .req(b_req), .mode(b_mode), .sel(b_sel),
    .grant(b_grant), .out(b_out), .out_ch(b_out_ch), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
`ifdef MUXN_STATS_EN
    , .xfer_cnt(b_xfer)
`endif
  );

  muxn_arb #(.W(8), .N(5)) u_c (
    .clk(clk), .rst_n(rst_n), .in(c_in), .req(c_req), .mode(c_mode), .sel(c_sel),
    .grant(c_grant), .out(c_out), .out_ch(c_out_ch), .out_valid(c_out_valid),
    .out_ready(c_out_ready)
`ifdef MUXN_STATS_EN
    , .xfer_cnt(c_xfer)
`endif
  );

  typedef struct {
    int          inst;
    logic        mode;
    logic [5:0]  sel;
    logic [63:0] req;
    logic        ready;
    logic [31:0] base;
    logic [63:0] exp_grant;
    logic [31:0] exp_data;
    logic [5:0]  exp_ch;
    logic        exp_vld;
  } vec_t;

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic [5:0]  ch;
    logic        vld;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input int inst, input logic mode, input int sel,
                              input logic [63:0] req, input logic ready, input logic [31:0] base,
                              input logic [63:0] g, input logic [31:0] d, input int ch,
                              input logic vld);
    vec_t v;
    v.inst = inst; v.mode = mode; v.sel = 6'(sel); v.req = req; v.ready = ready;
    v.base = base; v.exp_grant = g; v.exp_data = d; v.exp_ch = 6'(ch); v.exp_vld = vld;
    return v;
  endfunction

  function automatic logic [63:0] oh(input int k);
    return 64'(1) << k;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    case (v.inst)
      0: begin
        a_mode = v.mode; a_sel = v.sel[3:0]; a_req = v.req[15:0]; a_out_ready = v.ready;
        for (int k = 0; k < 16; k++) a_in[k*32 +: 32] = v.base + 32'(k);
      end
      1: begin
        b_mode = v.mode; b_sel = v.sel[1:0]; b_req = v.req[3:0]; b_out_ready = v.ready;
        for (int k = 0; k < 4; k++) b_in[k*8 +: 8] = 8'(v.base + 32'(k));
      end
      default: begin
        c_mode = v.mode; c_sel = v.sel[2:0]; c_req = v.req[4:0]; c_out_ready = v.ready;
        for (int k = 0; k < 5; k++) c_in[k*8 +: 8] = 8'(v.base + 32'(k));
      end
    endcase
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk); #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.inst)
        0: begin
          check("a.out", 64'(a_out), 64'(e.data));
          check("a.out_ch", 64'(a_out_ch), 64'(e.ch));
          check("a.out_valid", 64'(a_out_valid), 64'(e.vld));
        end
        1: begin
          check("b.out", 64'(b_out), 64'(e.data));
          check("b.out_ch", 64'(b_out_ch), 64'(e.ch));
          check("b.out_valid", 64'(b_out_valid), 64'(e.vld));
        end
        default: begin
          check("c.out", 64'(c_out), 64'(e.data));
          check("c.out_ch", 64'(c_out_ch), 64'(e.ch));
          check("c.out_valid", 64'(c_out_valid), 64'(e.vld));
        end
      endcase
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    logic [63:0] g;
    drive(v);
    #1;
    case (v.inst)
      0:       g = 64'(a_grant);
      1:       g = 64'(b_grant);
      default: g = 64'(c_grant);
    endcase
    check($sformatf("grant[inst%0d]", v.inst), g, v.exp_grant);
    e.inst = v.inst; e.data = v.exp_data; e.ch = v.exp_ch; e.vld = v.exp_vld;
    sbq.push_back(e);
    tick();
  endtask

  initial begin
    int rr_seq[7];

    // Direct sweep on the 16-channel instance, then a miss on an idle channel.
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(0, 0, k, 64'hFFFF, 1, 32'h100, oh(k), 32'h100 + 32'(k), k, 1));
    vecs.push_back(mk(0, 0, 3, 64'hFFF7, 1, 32'h100, 64'h0, 32'h10F, 15, 0));
    // Round-robin fairness on 4 channels with req=1011.
    rr_seq = '{0, 1, 3, 0, 1, 3, 0};
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1, 1, 0, 64'hB, 1, 32'hA0, oh(rr_seq[i]), 32'hA0 + 32'(rr_seq[i]),
                        rr_seq[i], 1));
    // 5-channel boundaries: out-of-range sel, empty round, wrap 4->0, ptr kept across direct.
    vecs.push_back(mk(2, 0, 2, 64'h1F, 1, 32'hC0, 64'h04, 32'hC2, 2, 1));
    vecs.push_back(mk(2, 0, 7, 64'h1F, 1, 32'hC0, 64'h00, 32'hC2, 2, 0));
    vecs.push_back(mk(2, 1, 0, 64'h00, 1, 32'hC0, 64'h00, 32'hC2, 2, 0));
    vecs.push_back(mk(2, 1, 0, 64'h10, 1, 32'hC0, 64'h10, 32'hC4, 4, 1));
    vecs.push_back(mk(2, 1, 0, 64'h1F, 1, 32'hC0, 64'h01, 32'hC0, 0, 1));
    vecs.push_back(mk(2, 0, 4, 64'h1F, 1, 32'hC0, 64'h10, 32'hC4, 4, 1));
    vecs.push_back(mk(2, 1, 0, 64'h1F, 1, 32'hC0, 64'h02, 32'hC1, 1, 1));
    vecs.push_back(mk(2, 1, 0, 64'h19, 1, 32'hC0, 64'h08, 32'hC3, 3, 1));
    vecs.push_back(mk(2, 1, 0, 64'h19, 1, 32'hC0, 64'h10, 32'hC4, 4, 1));
    vecs.push_back(mk(2, 1, 0, 64'h19, 1, 32'hC0, 64'h01, 32'hC0, 0, 1));

    // Reset with every instance requesting in round-robin mode: grants must stay low.
    rst_n = 1'b0;
    drive(mk(0, 1, 0, 64'hFFFF, 1, 32'h100, 0, 0, 0, 0));
    drive(mk(1, 1, 0, 64'hF, 1, 32'hA0, 0, 0, 0, 0));
    drive(mk(2, 1, 0, 64'h1F, 1, 32'hC0, 0, 0, 0, 0));
    #12;
    check("rst a.grant", 64'(a_grant), 64'h0);
    check("rst b.grant", 64'(b_grant), 64'h0);
    check("rst c.grant", 64'(c_grant), 64'h0);
    check("rst a.out", 64'(a_out), 64'h0);
    check("rst a.out_ch", 64'(a_out_ch), 64'h0);
    check("rst a.out_valid", 64'(a_out_valid), 64'h0);
    check("rst c.out_valid", 64'(c_out_valid), 64'h0);
    a_req = '0; b_req = '0; c_req = '0;
    #5 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) apply(vecs[i]);

    // Backpressure: word 0x105 held for 5 stalled cycles while inputs churn.
    apply(mk(0, 0, 5, 64'hFFFF, 1, 32'h100, oh(5), 32'h105, 5, 1));
    for (int c = 0; c < 5; c++)
      apply(mk(0, 0, c * 3, (c % 2 == 1) ? 64'hFFFF : 64'h0F0F, 0, 32'h200 + 32'(c * 16),
               64'h0, 32'h105, 5, 1));
    apply(mk(0, 0, 9, 64'hFFFF, 1, 32'h300, oh(9), 32'h309, 9, 1));
    apply(mk(0, 0, 10, 64'hFFFF, 1, 32'h300, oh(10), 32'h30A, 10, 1));

    // Reset mid-stall on the 4-channel instance (ptr sits at 1 here).
    apply(mk(1, 1, 0, 64'hF, 1, 32'hA0, 64'h2, 32'hA1, 1, 1));
    apply(mk(1, 1, 0, 64'hF, 0, 32'hA0, 64'h0, 32'hA1, 1, 1));
    #2 rst_n = 1'b0;
    #1;
    check("async b.out", 64'(b_out), 64'h0);
    check("async b.out_ch", 64'(b_out_ch), 64'h0);
    check("async b.out_valid", 64'(b_out_valid), 64'h0);
    check("async b.grant", 64'(b_grant), 64'h0);
    check("async a.out_valid", 64'(a_out_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 1, 0, 64'hF, 1, 32'hA0, 64'h1, 32'hA0, 0, 1));
    apply(mk(1, 1, 0, 64'hF, 1, 32'hA0, 64'h2, 32'hA1, 1, 1));

`ifdef MUXN_STATS_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("xfer_cnt reset", 64'(a_xfer), 64'h0);
    drive(mk(0, 0, 0, 64'hFFFF, 1, 32'h100, 0, 0, 0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("xfer_cnt early", 64'(a_xfer), 64'd2);
    repeat (69998) @(posedge clk);
    #1;
    check("xfer_cnt wrap", 64'(a_xfer), 64'd4464);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/muxn_arb.md
# muxn_arb

Parametrised N-channel, W-bit registered selector with a ready/valid output. It replaces the fixed 16-to-1 combinational mux tree where the datapath needs either direct steering or fair round-robin sharing of one consumer among several producers. Each input channel carries a request bit. The block grants one channel per accepted cycle and registers the selected word, its channel index and a valid flag, so the downstream stage sees registered outputs only.

## Interface
- W, 32, data width per channel (≥1)
- N, 16, channel count (2..64, any integer)
- SW, $clog2(N), select/index width (derived; not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset (clk is the single clock; reset asserts asynchronously, release is synchronous to clk)
- in  in  N*W  flattened channel data; channel k = in[k*W +: W]
- req  in  N  per-channel request, level-sensitive
- mode  in  1  0 = direct (sel), 1 = round-robin
- sel  in  SW  channel index used in direct mode
- grant  out  N  one-hot, combinational: channel captured at this edge
- out  out  W  registered selected data
- out_ch  out  SW  registered index of channel in `out`
- out_valid  out  1  `out` holds an untransferred word
- out_ready  in  1  consumer accepts `out` this cycle
- xfer_cnt  out  16  transfer counter (present only with MUXN_STATS_EN)

## Operation
- load = !out_valid || out_ready. The output register updates only when load = 1; otherwise out, out_ch and out_valid hold, and grant = 0.
- Direct mode, load = 1:
  - sel < N and req[sel] = 1: capture in[sel]; out_ch <= sel; out_valid <= 1; grant = onehot(sel).
  - Otherwise (including sel ≥ N): out_valid <= 0; out and out_ch hold; grant = 0.
- Round-robin mode, load = 1:
  - Search channels ptr, ptr+1, … N-1, 0, … ptr-1. The first with req = 1 wins.
  - On a win: capture data; out_ch <= win; out_valid <= 1; grant = onehot(win); ptr <= (win+1) mod N, which wraps N-1 → 0.
  - No request: out_valid <= 0; ptr holds; grant = 0.
- ptr (SW bits) updates only on a round-robin grant. It is retained across direct-mode cycles.
- mode and sel are sampled each cycle. A change applies to the next load with no flush, and a held output word is not affected.
- grant is never asserted when load = 0. At most one grant bit is set.
- Reset, asynchronous: out = 0, out_ch = 0, out_valid = 0, ptr = 0, xfer_cnt = 0. grant = 0 while rst_n = 0.

## Timing
- Latency 1 cycle: a req/data sampled at edge t appears on out after edge t.
- Throughput is one word per cycle while out_ready = 1.
- Stall: with out_valid = 1 and out_ready = 0, outputs are frozen indefinitely. Producers must keep req asserted to be served later; grant is the only acknowledge.
- Simultaneous transfer and new capture in the same cycle (out_valid = out_ready = 1 and a request present) is allowed. It yields back-to-back valid words.
- Reset mid-stall drops the held word. After release, the first edge with a request is served from channel 0 onward in round-robin mode.

## Configuration
- MUXN_STATS_EN defined: add the 16-bit xfer_cnt port.
  - It increments on every edge with out_valid && out_ready and wraps 0xFFFF → 0x0000.
  - Its reset value is 0.
- MUXN_STATS_EN undefined: neither the port nor the counter exists. All other behaviour is identical.

## Test plan
- Direct steering, N=16, W=32, mode=0, out_ready=1, all req=1, channel k data = 0x100+k. Sweep sel 0..15 → out follows 0x100..0x10F one cycle later; out_ch = sel; grant one-hot each cycle.
- Round-robin fairness, N=4, mode=1, req=4'b1011 constant, out_ready=1 → out_ch sequence 0,1,3,0,1,3…; ptr wraps 3 → 0.
- Backpressure: out_valid=1, out_ready=0 held for 5 cycles while data and req change → out, out_ch, out_valid frozen and grant=0 all 5 cycles; release → next word captured the same cycle.
- Boundaries: N=5, mode=0, sel=7 → out_valid deasserts after the next load. Round-robin with req=0 → out_valid=0 and ptr unchanged; then req=5'b10000 → out_ch=4 and ptr becomes 0.
- Reset mid-operation: assert rst_n=0 between edges while out_valid=1 → outputs 0 immediately, without waiting for an edge. Release with req=all ones, mode=1 → first out_ch=0.
- MUXN_STATS_EN: 70000 accepted transfers → xfer_cnt = 70000 mod 65536 = 4464. Without the macro the build has no xfer_cnt port.
